// File: rtl/dir_input_ctrl.sv
// Direction input controller: synchronises and debounces per-player buttons and
// queues legal direction changes, applying one queued move per player on each step.
module dir_input_ctrl #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         DB_CYCLES   = 16,
  parameter int         QDEPTH      = 4,
  parameter logic [1:0] INIT_DIR    = 2'b11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4*NUM_PLAYERS-1:0] btn,
  input  logic                     step,
  output logic [2*NUM_PLAYERS-1:0] move,
  output logic [NUM_PLAYERS-1:0]   dir_changed,
  output logic [NUM_PLAYERS-1:0]   q_overflow
);

  localparam int NB = 4 * NUM_PLAYERS;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(QDEPTH);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_d;
  logic [NB-1:0] press_r;

  // step is a bare strobe with no handshake: a pop happens on any edge where
  // step=1 and the queue holds an entry; a step on an empty queue is ignored.

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb_d   <= '0;
      press_r <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      deb_d   <= deb;
      press_r <= deb & ~deb_d;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          lvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = lvl;
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    logic [1:0]    mem [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] tail_ptr;
    logic [PW:0]   count;
    logic [1:0]    move_r;
    logic          dc_r;
    logic          ovf_r;
    logic [3:0]    pr;
    logic          sel_valid;
    logic [1:0]    sel_dir;
    logic [1:0]    ref_dir;
    logic          push_req;
    logic          pop;
    logic          full;
    logic          push;
    logic          ovf_set;

    assign pr       = press_r[4*p +: 4];
    assign tail_ptr = wr_ptr - 1'b1;

    always_comb begin
      sel_valid = |pr;
      sel_dir   = 2'b11;
      if (pr[3])      sel_dir = 2'b00;
      else if (pr[2]) sel_dir = 2'b01;
      else if (pr[1]) sel_dir = 2'b10;
      ref_dir  = (count != '0) ? mem[tail_ptr] : move_r;
      // Equal or reverse direction both share bit1 with the reference.
      push_req = sel_valid && (sel_dir[1] != ref_dir[1]);
      pop      = step && (count != '0);
      full     = (count == FULL_CNT);
      push     = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        move_r <= INIT_DIR;
        dc_r   <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= sel_dir;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) begin
          move_r <= mem[rd_ptr];
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        dc_r <= pop;
        if (ovf_set) ovf_r <= 1'b1;
      end
    end

    assign move[2*p +: 2] = move_r;
    assign dir_changed[p] = dc_r;
    assign q_overflow[p]  = ovf_r;
  end

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl: expected moves are queued at each step and a
// negedge monitor checks every dir_changed pulse, the held moves and flag requests.
module tb_dir_input_ctrl;

  localparam int         NP   = 2;
  localparam int         DB   = 4;
  localparam int         QD   = 4;
  localparam logic [1:0] INIT = 2'b11;

  logic            clk;
  logic            rst;
  logic [4*NP-1:0] btn;
  logic            step;
  logic [2*NP-1:0] move;
  logic [NP-1:0]   dir_changed;
  logic [NP-1:0]   q_overflow;

  typedef struct {
    int         kind;
    logic [1:0] exp;
  } chk_t;

  logic [1:0] exp_q0[$];
  logic [1:0] exp_q1[$];
  chk_t       chk_q[$];
  logic [1:0] exp_cur [NP];
  int         total;
  int         bad;

  dir_input_ctrl #(
    .NUM_PLAYERS(NP), .DB_CYCLES(DB), .QDEPTH(QD), .INIT_DIR(INIT)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .step(step),
    .move(move), .dir_changed(dir_changed), .q_overflow(q_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    total = 0;
    bad   = 0;
    for (int p = 0; p < NP; p++) exp_cur[p] = INIT;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) exp_cur[p] = INIT;
    end else begin
      if (dir_changed[0]) begin
        total++;
        if (exp_q0.size() == 0) begin
          bad++;
          $display("FAIL p0_pulse unexpected dir_changed move=%0h", move[1:0]);
        end else exp_cur[0] = exp_q0.pop_front();
      end
      if (dir_changed[1]) begin
        total++;
        if (exp_q1.size() == 0) begin
          bad++;
          $display("FAIL p1_pulse unexpected dir_changed move=%0h", move[3:2]);
        end else exp_cur[1] = exp_q1.pop_front();
      end
      for (int p = 0; p < NP; p++) begin
        total++;
        if (move[2*p +: 2] !== exp_cur[p]) begin
          bad++;
          $display("FAIL move_p%0d t=%0t act=%0h exp=%0h", p, $time, move[2*p +: 2], exp_cur[p]);
        end
      end
      while (chk_q.size() > 0) begin
        chk_t c;
        c = chk_q.pop_front();
        total++;
        case (c.kind)
          0: if (q_overflow !== c.exp) begin
               bad++;
               $display("FAIL q_overflow act=%0b exp=%0b", q_overflow, c.exp);
             end
          1: if (dir_changed !== c.exp) begin
               bad++;
               $display("FAIL dir_changed act=%0b exp=%0b", dir_changed, c.exp);
             end
          default: if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
               bad++;
               $display("FAIL missing_pulses act=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size());
             end
        endcase
      end
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int p, input logic [3:0] bits, input int hold);
    btn[4*p +: 4] = bits;
    cyc(hold);
    btn[4*p +: 4] = 4'b0000;
    cyc(12);
  endtask

  task automatic do_step(input logic v0, input logic [1:0] e0,
                         input logic v1, input logic [1:0] e1);
    if (v0) exp_q0.push_back(e0);
    if (v1) exp_q1.push_back(e1);
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(3);
  endtask

  task automatic req(input int kind, input logic [1:0] e);
    chk_t c;
    c.kind = kind;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LT = 4'b0010, RT = 4'b0001;

  initial begin
    rst  = 1'b1;
    btn  = '0;
    step = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    req(0, 2'b00);
    req(1, 2'b00);
    cyc(2);

    // latency: push lands at edge 7, so a step at edge 6 finds nothing
    btn[3:0] = UP;
    cyc(6);
    step = 1'b1; cyc(1); step = 1'b0;
    cyc(3);
    exp_q0.push_back(2'b00);
    step = 1'b1; cyc(1); step = 1'b0;
    btn[3:0] = 4'b0000;
    cyc(12);

    // glitch shorter than debounce is ignored, longer one registers
    press(0, LT, 3);
    do_step(0, 2'b00, 0, 2'b00);
    press(0, LT, 5);
    do_step(1, 2'b10, 0, 2'b00);

    // reach right, then equal/reverse filtering against move and tail
    press(0, UP, 6); do_step(1, 2'b00, 0, 2'b00);
    press(0, RT, 6); do_step(1, 2'b11, 0, 2'b00);
    press(0, LT, 6);
    press(0, RT, 6);
    press(0, UP, 6);
    press(0, DN, 6);
    do_step(1, 2'b00, 0, 2'b00);
    do_step(0, 2'b00, 0, 2'b00);

    // overflow: four queued, fifth dropped, flag sticky
    press(0, RT, 6); do_step(1, 2'b11, 0, 2'b00);
    press(0, UP, 6);
    press(0, LT, 6);
    press(0, DN, 6);
    press(0, RT, 6);
    req(0, 2'b00);
    press(0, UP, 6);
    req(0, 2'b01);
    do_step(1, 2'b00, 0, 2'b00);
    do_step(1, 2'b10, 0, 2'b00);
    do_step(1, 2'b01, 0, 2'b00);
    do_step(1, 2'b11, 0, 2'b00);
    do_step(0, 2'b00, 0, 2'b00);
    req(0, 2'b01);

    // player 1: same-cycle up+right, up wins
    press(1, UP, 6); do_step(0, 2'b00, 1, 2'b00);
    press(1, LT, 6); do_step(0, 2'b00, 1, 2'b10);
    press(1, UP | RT, 6);
    do_step(0, 2'b00, 1, 2'b00);
    do_step(0, 2'b00, 0, 2'b00);

    // reset with queued entries and a debounce in flight
    press(0, UP, 6);
    press(0, LT, 6);
    press(0, DN, 6);
    btn[3:0] = RT;
    cyc(3);
    rst = 1'b1;
    btn = '0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    req(0, 2'b00);
    req(1, 2'b00);
    cyc(12);
    do_step(0, 2'b00, 0, 2'b00);

    // button held through reset gives exactly one press
    btn[7:4] = DN;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(12);
    btn[7:4] = 4'b0000;
    cyc(12);
    do_step(0, 2'b00, 1, 2'b01);
    do_step(0, 2'b00, 0, 2'b00);

    cyc(2);
    req(2, 2'b00);
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
